neuron_layer_ctrl: RTL and testbench
====================================

NEURON_LAYER_CTRL -- requirements
Module: neuron_layer_ctrl

Interface
REQ-001 Parameter: WT_AW, default 16, weight memory address width.
REQ-002 Parameter: RES_AW, default 10, result memory address width.
REQ-003 sys_clk  input  1  clock; all logic on the rising edge.
REQ-004 sys_rst_n  input  1  reset: asynchronous, active-low.
REQ-005 start  input  1  one-cycle pulse; begins a layer run when idle.
REQ-006 cfg_in_length  input  16  MACs per neuron (N); sampled at start.
REQ-007 cfg_num_neurons  input  16  neurons per layer (M); sampled at start.
REQ-008 busy  output  1  high from the accepted start until done.
REQ-009 done  output  1  one-cycle pulse at the end of the run.
REQ-010 err  output  1  sticky; set on a config error or quant timeout; cleared by the next accepted start.
REQ-011 act_rd_en / act_addr  output  1 / 16  activation memory read; data valid 1 cycle later.
REQ-012 act_rdata  input  8  signed activation.
REQ-013 wt_rd_en / wt_addr  output  1 / WT_AW  weight memory read; 1-cycle latency.
REQ-014 wt_rdata  input  8  signed weight.
REQ-015 nrn_activ / nrn_weight  output  8 / 8  operands to the neuron; act_rdata and wt_rdata passed straight through.
REQ-016 nrn_in_valid  output  1  registered copy of the read enable, delayed 1 cycle.
REQ-017 nrn_in_length  output  16  latched N.
REQ-018 nrn_thr_valid  output  1  neuron threshold_valid.
REQ-019 nrn_quant_ready / nrn_out / nrn_out_valid  input  1 / 8 / 1  returned by the neuron.
REQ-020 res_wr_en / res_addr / res_wdata  output  1 / RES_AW / 8  result memory write port.

Function
REQ-021 States: IDLE, STREAM, DRAIN, WAIT_SUM, QUANT, WRITE, NEXT.
- IDLE: start accepted with N>0 and M>0 -> STREAM; neuron index i=0; wt_base=0.
- Start with N==0 or M==0: err=1, done pulse 1 cycle later, no reads, no writes; FSM returns to IDLE.
- A start asserted while busy is ignored.
REQ-022 STREAM: issue exactly N back-to-back reads, one per cycle, with no gaps.
- act_addr = k; wt_addr = wt_base + k; k = 0..N-1.
- After the read with k = N-1 -> DRAIN.
REQ-023 DRAIN: 1 cycle, letting the last nrn_in_valid reach the neuron -> WAIT_SUM.
REQ-024 WAIT_SUM: wait for nrn_quant_ready -> QUANT.
REQ-025 QUANT: hold nrn_thr_valid=1 until nrn_out_valid; on nrn_out_valid, capture nrn_out -> WRITE.
REQ-026 Watchdog: a 9-bit counter runs in QUANT and in WAIT_SUM.
- Reaching 511 without the expected event: err=1, FSM -> IDLE, done pulse.
REQ-027 WRITE: 1 cycle with res_wr_en=1, res_addr=i[RES_AW-1:0], res_wdata=captured value; nrn_thr_valid=0 -> NEXT.
REQ-028 NEXT: wt_base += N (accumulator; no multiplier).
- i == M-1: done pulse, busy=0, -> IDLE.
- Otherwise i++, -> STREAM.
- nrn_thr_valid stays low at least 1 cycle between neurons so the neuron's quant counter restarts.
REQ-029 wt_addr arithmetic wraps modulo 2^WT_AW; res_addr wraps modulo 2^RES_AW; no error is flagged for either wrap.
REQ-030 Latency per neuron = N + 1 (drain) + sum wait + ~255 quant + 2 (write, next) cycles; done follows the last WRITE by exactly 1 cycle.
REQ-031 nrn_in_valid is never high outside the cycle after a STREAM read.
REQ-032 nrn_in_valid and nrn_thr_valid are never high in the same cycle.

Reset
REQ-033 On sys_rst_n low, immediately:
- FSM = IDLE.
- Outputs: busy, done, err, act_rd_en, wt_rd_en, nrn_in_valid, nrn_thr_valid, res_wr_en = 0; all address and data outputs = 0.
- Latched N and M = 0.
REQ-034 Reset mid-run abandons the run: no done pulse, and no further writes after release.

Structure
REQ-035 Shared package bika_pkg holds:
- the state enumeration;
- the constants ACT_W=8, LEN_W=16, WDOG_MAX=511, QUANT_STEPS=255.
REQ-036 Natural sub-module: nrn_addr_gen, which produces k and wt_base and the read enables.
- The FSM, watchdog and write port stay in neuron_layer_ctrl.

Verification
REQ-037 N=4, M=2, with the real neuron and memories: 4 gap-free reads per neuron; wt_addr 0-3 then 4-7; 2 writes to res_addr 0 and 1; one done pulse; err=0.
REQ-038 Start with N=0, M=3: err=1; done 1 cycle later; zero reads and writes.
REQ-039 Start pulsed again during the run with N=4, M=2: ignored; wt_addr sequence and write count unchanged.
REQ-040 Stubbed neuron that never asserts nrn_out_valid: err=1 and done after 511 QUANT cycles; no res_wr_en.
REQ-041 sys_rst_n low for 2 cycles mid-STREAM of neuron 1: all outputs 0 immediately; no done pulse; busy=0.
REQ-042 Activations all +1, weights all -1, N=3: sum is negative; res_wdata=0. Weights all +1: res_wdata=255 as 8-bit (reads as -1 signed).

Source files
------------

// File: rtl/bika_pkg.sv
// Shared types and constants for the neuron layer controller and its address generator.
package bika_pkg;

  localparam int ACT_W       = 8;
  localparam int LEN_W       = 16;
  localparam int WDOG_MAX    = 511;
  localparam int QUANT_STEPS = 255;

  typedef enum logic [2:0] {
    IDLE,
    STREAM,
    DRAIN,
    WAIT_SUM,
    QUANT,
    WRITE,
    NEXT
  } layer_state_t;

  // A layer with no inputs or no neurons cannot run.
  function automatic logic cfg_bad(input logic [LEN_W-1:0] n, input logic [LEN_W-1:0] m);
    return (n == '0) || (m == '0);
  endfunction

endpackage

// File: rtl/nrn_addr_gen.sv
// Read address generator: k sweeps 0..N-1 per neuron, weight addresses run on from a base that advances by N.
module nrn_addr_gen
  import bika_pkg::*;
#(
  parameter int WT_AW = 16
) (
  input  logic             sys_clk,
  input  logic             sys_rst_n,
  input  logic             run_start,
  input  logic             nrn_next,
  input  logic             nrn_go,
  input  logic [LEN_W-1:0] len,
  output logic             rd_en,
  output logic [LEN_W-1:0] k,
  output logic [WT_AW-1:0] wt_addr,
  output logic             last_rd
);

  logic [WT_AW-1:0] wt_base;
  logic [WT_AW-1:0] base_nxt;

  assign base_nxt = wt_base + WT_AW'(len);
  assign last_rd  = rd_en && (k == len - 16'd1);

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      wt_base <= '0;
      wt_addr <= '0;
      k       <= '0;
      rd_en   <= 1'b0;
    end else if (run_start) begin
      wt_base <= '0;
      wt_addr <= '0;
      k       <= '0;
      rd_en   <= 1'b1;
    end else if (nrn_next) begin
      wt_base <= base_nxt;
      if (nrn_go) begin
        wt_addr <= base_nxt;
        k       <= '0;
        rd_en   <= 1'b1;
      end
    end else if (rd_en) begin
      if (last_rd) begin
        rd_en <= 1'b0;
      end else begin
        k       <= k + 16'd1;
        wt_addr <= wt_addr + 1'b1;
      end
    end
  end

endmodule

// File: rtl/neuron_layer_ctrl.sv
// Sequences one layer: streams N operand pairs per neuron, waits for the neuron's sum and
// quantised output under a watchdog, and writes one result per neuron.
module neuron_layer_ctrl
  import bika_pkg::*;
#(
  parameter int WT_AW  = 16,
  parameter int RES_AW = 10
) (
  input  logic                    sys_clk,
  input  logic                    sys_rst_n,
  input  logic                    start,
  input  logic [LEN_W-1:0]        cfg_in_length,
  input  logic [LEN_W-1:0]        cfg_num_neurons,
  output logic                    busy,
  output logic                    done,
  output logic                    err,
  output logic                    act_rd_en,
  output logic [LEN_W-1:0]        act_addr,
  input  logic signed [ACT_W-1:0] act_rdata,
  output logic                    wt_rd_en,
  output logic [WT_AW-1:0]        wt_addr,
  input  logic signed [ACT_W-1:0] wt_rdata,
  output logic signed [ACT_W-1:0] nrn_activ,
  output logic signed [ACT_W-1:0] nrn_weight,
  output logic                    nrn_in_valid,
  output logic [LEN_W-1:0]        nrn_in_length,
  output logic                    nrn_thr_valid,
  input  logic                    nrn_quant_ready,
  input  logic [ACT_W-1:0]        nrn_out,
  input  logic                    nrn_out_valid,
  output logic                    res_wr_en,
  output logic [RES_AW-1:0]       res_addr,
  output logic [ACT_W-1:0]        res_wdata
);

  layer_state_t     state;
  logic [LEN_W-1:0] m_num;
  logic [LEN_W-1:0] nrn_idx;
  logic [8:0]       wdog;
  logic             start_ok;
  logic             last_nrn;
  logic             last_rd;
  logic             wdog_exp;

  assign start_ok   = (state == IDLE) && start && !cfg_bad(cfg_in_length, cfg_num_neurons);
  assign last_nrn   = (nrn_idx == m_num - 16'd1);
  assign wdog_exp   = (wdog == 9'(WDOG_MAX - 1));
  assign nrn_activ  = act_rdata;
  assign nrn_weight = wt_rdata;
  assign wt_rd_en   = act_rd_en;

  nrn_addr_gen #(
    .WT_AW(WT_AW)
  ) u_addr_gen (
    .sys_clk  (sys_clk),
    .sys_rst_n(sys_rst_n),
    .run_start(start_ok),
    .nrn_next (state == NEXT),
    .nrn_go   ((state == NEXT) && !last_nrn),
    .len      (nrn_in_length),
    .rd_en    (act_rd_en),
    .k        (act_addr),
    .wt_addr  (wt_addr),
    .last_rd  (last_rd)
  );

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state         <= IDLE;
      nrn_in_length <= '0;
      m_num         <= '0;
      nrn_idx       <= '0;
      wdog          <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
      err           <= 1'b0;
      nrn_in_valid  <= 1'b0;
      nrn_thr_valid <= 1'b0;
      res_wr_en     <= 1'b0;
      res_addr      <= '0;
      res_wdata     <= '0;
    end else begin
      done         <= 1'b0;
      res_wr_en    <= 1'b0;
      // Memory data arrives one cycle after the read, so the valid follows the enable by one cycle.
      nrn_in_valid <= act_rd_en;
      case (state)
        IDLE: begin
          if (start) begin
            nrn_in_length <= cfg_in_length;
            m_num         <= cfg_num_neurons;
            if (cfg_bad(cfg_in_length, cfg_num_neurons)) begin
              err  <= 1'b1;
              done <= 1'b1;
            end else begin
              err     <= 1'b0;
              busy    <= 1'b1;
              nrn_idx <= '0;
              state   <= STREAM;
            end
          end
        end
        STREAM: begin
          if (last_rd) state <= DRAIN;
        end
        DRAIN: begin
          wdog  <= '0;
          state <= WAIT_SUM;
        end
        WAIT_SUM: begin
          if (nrn_quant_ready) begin
            wdog          <= '0;
            nrn_thr_valid <= 1'b1;
            state         <= QUANT;
          end else if (wdog_exp) begin
            err   <= 1'b1;
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            wdog <= wdog + 9'd1;
          end
        end
        QUANT: begin
          if (nrn_out_valid) begin
            res_wdata     <= nrn_out;
            res_addr      <= RES_AW'(nrn_idx);
            res_wr_en     <= 1'b1;
            nrn_thr_valid <= 1'b0;
            state         <= WRITE;
          end else if (wdog_exp) begin
            nrn_thr_valid <= 1'b0;
            err           <= 1'b1;
            done          <= 1'b1;
            busy          <= 1'b0;
            state         <= IDLE;
          end else begin
            wdog <= wdog + 9'd1;
          end
        end
        WRITE: begin
          // Done is raised here so it lands exactly one cycle after the final write.
          if (last_nrn) begin
            done <= 1'b1;
            busy <= 1'b0;
          end
          state <= NEXT;
        end
        NEXT: begin
          if (last_nrn) begin
            state <= IDLE;
          end else begin
            nrn_idx <= nrn_idx + 16'd1;
            state   <= STREAM;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_neuron_layer_ctrl.sv
// Directed bench for neuron_layer_ctrl with behavioural memories and a hard-threshold neuron model.
module tb_neuron_layer_ctrl;
  import bika_pkg::*;

  logic              sys_clk = 1'b0;
  logic              sys_rst_n = 1'b0;
  logic              start = 1'b0;
  logic [15:0]       cfg_in_length = '0;
  logic [15:0]       cfg_num_neurons = '0;
  logic              busy, done, err;
  logic              act_rd_en, wt_rd_en;
  logic [15:0]       act_addr;
  logic [15:0]       wt_addr;
  logic signed [7:0] act_rdata = '0;
  logic signed [7:0] wt_rdata = '0;
  logic signed [7:0] nrn_activ, nrn_weight;
  logic              nrn_in_valid, nrn_thr_valid;
  logic [15:0]       nrn_in_length;
  logic              nrn_quant_ready;
  logic [7:0]        nrn_out = '0;
  logic              nrn_out_valid = 1'b0;
  logic              res_wr_en;
  logic [9:0]        res_addr;
  logic [7:0]        res_wdata;

  neuron_layer_ctrl #(.WT_AW(16), .RES_AW(10)) dut (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .start(start),
    .cfg_in_length(cfg_in_length), .cfg_num_neurons(cfg_num_neurons),
    .busy(busy), .done(done), .err(err),
    .act_rd_en(act_rd_en), .act_addr(act_addr), .act_rdata(act_rdata),
    .wt_rd_en(wt_rd_en), .wt_addr(wt_addr), .wt_rdata(wt_rdata),
    .nrn_activ(nrn_activ), .nrn_weight(nrn_weight), .nrn_in_valid(nrn_in_valid),
    .nrn_in_length(nrn_in_length), .nrn_thr_valid(nrn_thr_valid),
    .nrn_quant_ready(nrn_quant_ready), .nrn_out(nrn_out), .nrn_out_valid(nrn_out_valid),
    .res_wr_en(res_wr_en), .res_addr(res_addr), .res_wdata(res_wdata)
  );

  always #5 sys_clk = ~sys_clk;

  // Memories with one-cycle read latency
  logic signed [7:0] act_mem [0:15];
  logic signed [7:0] wt_mem  [0:255];
  always @(posedge sys_clk) begin
    if (act_rd_en) act_rdata <= act_mem[act_addr[3:0]];
    if (wt_rd_en)  wt_rdata  <= wt_mem[wt_addr[7:0]];
  end

  // Neuron model: sum of products, then QUANT_STEPS threshold cycles; output 255 if sum > 0 else 0
  logic stub = 1'b0;
  logic nrn_clr = 1'b0;
  int   in_cnt, acc, qstep;
  assign nrn_quant_ready = (in_cnt != 0) && (in_cnt == int'(nrn_in_length));
  always @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      in_cnt <= 0; acc <= 0; qstep <= 0; nrn_out_valid <= 1'b0; nrn_out <= '0;
    end else if (nrn_clr) begin
      in_cnt <= 0; acc <= 0; qstep <= 0; nrn_out_valid <= 1'b0;
    end else begin
      nrn_out_valid <= 1'b0;
      if (nrn_in_valid) begin
        in_cnt <= in_cnt + 1;
        acc    <= acc + int'(nrn_activ) * int'(nrn_weight);
      end
      if (nrn_thr_valid && !nrn_out_valid) begin
        if (!stub && qstep == QUANT_STEPS - 1) begin
          nrn_out_valid <= 1'b1;
          nrn_out       <= (acc > 0) ? 8'hFF : 8'h00;
          qstep <= 0; in_cnt <= 0; acc <= 0;
        end else begin
          qstep <= qstep + 1;
        end
      end else if (!nrn_thr_valid) begin
        qstep <= 0;
      end
    end
  end

  // Monitor, sampled on the falling edge
  int pcnt = 0;
  always @(posedge sys_clk) pcnt <= pcnt + 1;

  int          rd_cnt, bursts, viol, thr_cnt, done_cnt, done_pc, last_wr_pc, last_thr_pc;
  logic        prev_rd = 1'b0;
  logic [15:0] wt_log[$];
  logic [15:0] act_log[$];
  logic [9:0]  wa_log[$];
  logic [7:0]  wd_log[$];

  always @(negedge sys_clk) begin
    if (act_rd_en) begin
      rd_cnt = rd_cnt + 1;
      wt_log.push_back(wt_addr);
      act_log.push_back(act_addr);
      if (!prev_rd) bursts = bursts + 1;
    end
    if (nrn_in_valid != prev_rd) viol = viol + 1;
    if (nrn_in_valid && nrn_thr_valid) viol = viol + 1;
    if (nrn_thr_valid) begin thr_cnt = thr_cnt + 1; last_thr_pc = pcnt; end
    if (res_wr_en) begin wa_log.push_back(res_addr); wd_log.push_back(res_wdata); last_wr_pc = pcnt; end
    if (done) begin done_cnt = done_cnt + 1; done_pc = pcnt; end
    prev_rd = act_rd_en;
  end

  int n_chk = 0;
  int n_pass = 0;
  task automatic check(input string nm, input longint act, input longint exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
  endtask

  task automatic clear_logs();
    rd_cnt = 0; bursts = 0; viol = 0; thr_cnt = 0; done_cnt = 0;
    done_pc = 0; last_wr_pc = 0; last_thr_pc = 0;
    wt_log.delete(); act_log.delete(); wa_log.delete(); wd_log.delete();
  endtask

  int start_pc;
  task automatic run_layer(input int n, input int m, input logic signed [7:0] a,
                           input logic signed [7:0] w0, input logic signed [7:0] w1,
                           input int dup_at, output int timed_out);
    for (int j = 0; j < 16; j++)  act_mem[j] = a;
    for (int j = 0; j < 256; j++) wt_mem[j] = (j < n) ? w0 : w1;
    nrn_clr = 1'b1; @(posedge sys_clk); #1; nrn_clr = 1'b0;
    clear_logs();
    cfg_in_length = 16'(n); cfg_num_neurons = 16'(m); start = 1'b1;
    @(posedge sys_clk); #1;
    start_pc = pcnt; start = 1'b0;
    timed_out = 1;
    for (int c = 0; c < 4000; c++) begin
      if (dup_at != 0 && c == dup_at) begin
        cfg_in_length = 16'd2; cfg_num_neurons = 16'd5; start = 1'b1;
        @(posedge sys_clk); #1;
        start = 1'b0; cfg_in_length = 16'(n); cfg_num_neurons = 16'(m);
      end else begin
        @(posedge sys_clk); #1;
      end
      if (done_cnt != 0) begin timed_out = 0; break; end
    end
    repeat (3) @(posedge sys_clk);
    #1;
  endtask

  typedef struct {
    int                n;
    int                m;
    logic signed [7:0] a;
    logic signed [7:0] w0;
    logic signed [7:0] w1;
    logic              exp_err;
    logic [7:0]        exp_d0;
    logic [7:0]        exp_d1;
  } vec_t;

  vec_t vecs[7];

  task automatic check_run(input string tag, input int n, input int m, input logic exp_err,
                           input logic [7:0] d0, input logic [7:0] d1, input int to);
    int bad_wt, bad_act, bad_wa, bad_wd;
    check({tag, "_timeout"}, to, 0);
    check({tag, "_err"}, err, exp_err);
    check({tag, "_done_cnt"}, done_cnt, 1);
    check({tag, "_busy_end"}, busy, 0);
    check({tag, "_reads"}, rd_cnt, exp_err ? 0 : n * m);
    check({tag, "_bursts"}, bursts, exp_err ? 0 : m);
    check({tag, "_writes"}, wa_log.size(), exp_err ? 0 : m);
    check({tag, "_protocol"}, viol, 0);
    if (exp_err) check({tag, "_done_lat"}, done_pc - start_pc, 0);
    else         check({tag, "_done_lat"}, done_pc - last_wr_pc, 1);
    bad_wt = 0; bad_act = 0; bad_wa = 0; bad_wd = 0;
    for (int j = 0; j < wt_log.size(); j++) begin
      if (wt_log[j] != 16'(j)) bad_wt++;
      if (act_log[j] != 16'(j % n)) bad_act++;
    end
    for (int j = 0; j < wa_log.size(); j++) begin
      if (wa_log[j] != 10'(j)) bad_wa++;
      if (wd_log[j] != ((j == 0) ? d0 : d1)) bad_wd++;
    end
    check({tag, "_wt_addr_seq_bad"}, bad_wt, 0);
    check({tag, "_act_addr_seq_bad"}, bad_act, 0);
    check({tag, "_res_addr_bad"}, bad_wa, 0);
    check({tag, "_res_wdata_bad"}, bad_wd, 0);
  endtask

  initial begin
    int to;
    vecs[0] = '{4, 2,  1,  1, -1, 1'b0, 8'hFF, 8'h00};
    vecs[1] = '{0, 3,  1,  1,  1, 1'b1, 8'h00, 8'h00};
    vecs[2] = '{3, 1,  1, -1, -1, 1'b0, 8'h00, 8'h00};
    vecs[3] = '{3, 1,  1,  1,  1, 1'b0, 8'hFF, 8'hFF};
    vecs[4] = '{2, 0,  1,  1,  1, 1'b1, 8'h00, 8'h00};
    vecs[5] = '{1, 3,  2, -1,  1, 1'b0, 8'h00, 8'hFF};
    vecs[6] = '{5, 2, -3,  2, -2, 1'b0, 8'h00, 8'hFF};
    clear_logs();

    // Reset state
    repeat (2) @(posedge sys_clk);
    #1;
    check("reset_ctrl", {busy, done, err, act_rd_en, wt_rd_en, nrn_in_valid, nrn_thr_valid, res_wr_en}, 0);
    check("reset_data", {act_addr, wt_addr, res_addr, res_wdata, nrn_in_length}, 0);
    sys_rst_n = 1'b1;
    repeat (2) @(posedge sys_clk);
    #1;
    check("idle_busy", busy, 0);

    for (int i = 0; i < 7; i++) begin
      run_layer(vecs[i].n, vecs[i].m, vecs[i].a, vecs[i].w0, vecs[i].w1, 0, to);
      check_run($sformatf("v%0d", i), vecs[i].n, vecs[i].m, vecs[i].exp_err,
                vecs[i].exp_d0, vecs[i].exp_d1, to);
    end

    // Second start during the run is ignored
    run_layer(4, 2, 1, 1, -1, 30, to);
    check_run("dup_start", 4, 2, 1'b0, 8'hFF, 8'h00, to);

    // Neuron never returns an output: watchdog ends the run
    stub = 1'b1;
    run_layer(2, 1, 1, 1, 1, 0, to);
    check("wdog_timeout", to, 0);
    check("wdog_err", err, 1);
    check("wdog_thr_cycles", thr_cnt, WDOG_MAX);
    check("wdog_writes", wa_log.size(), 0);
    check("wdog_done_cnt", done_cnt, 1);
    check("wdog_done_lat", done_pc - last_thr_pc, 1);
    check("wdog_busy", busy, 0);
    stub = 1'b0;

    // Reset mid-STREAM of neuron 1
    for (int j = 0; j < 16; j++)  act_mem[j] = 1;
    for (int j = 0; j < 256; j++) wt_mem[j] = 1;
    nrn_clr = 1'b1; @(posedge sys_clk); #1; nrn_clr = 1'b0;
    clear_logs();
    cfg_in_length = 16'd4; cfg_num_neurons = 16'd2; start = 1'b1;
    @(posedge sys_clk); #1;
    start = 1'b0;
    to = 1;
    for (int c = 0; c < 2000; c++) begin
      @(posedge sys_clk); #1;
      if (wa_log.size() == 1 && act_rd_en) begin to = 0; break; end
    end
    check("rst_reach_stream1", to, 0);
    check("rst_pre_busy", busy, 1);
    sys_rst_n = 1'b0;
    #1;
    check("rst_mid_ctrl", {busy, done, err, act_rd_en, wt_rd_en, nrn_in_valid, nrn_thr_valid, res_wr_en}, 0);
    check("rst_mid_data", {act_addr, wt_addr, res_addr, res_wdata, nrn_in_length}, 0);
    repeat (2) @(posedge sys_clk);
    #1;
    sys_rst_n = 1'b1;
    clear_logs();
    repeat (1000) @(posedge sys_clk);
    #1;
    check("rst_after_done", done_cnt, 0);
    check("rst_after_writes", wa_log.size(), 0);
    check("rst_after_reads", rd_cnt, 0);
    check("rst_after_busy", busy, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
